// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared types and constants for the multi-cycle MIPS control
//             sequencer: FSM state encoding, opcode/funct fields and ALU
//             operation codes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // State encoding is visible on the sequencer's state port.
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    // Primary opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // R-type function field IR[5:0]
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes driven on aluop
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_decode
//  Purpose  : Combinational instruction decoder. Maps a 32-bit instruction
//             word to ALU control and a legality flag.
//  Ports    : i_ir          - instruction register contents
//             o_aluop       - ALU operation code
//             o_alu_src_imm - select sign-extended imm16 as ALU operand B
//             o_wr_en       - instruction writes the register file
//             o_legal       - instruction is decodable
//  Revision : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [2:0]  o_aluop,
    output logic        o_alu_src_imm,
    output logic        o_wr_en,
    output logic        o_legal
);

    logic [5:0] w_op;
    logic [5:0] w_funct;

    assign w_op    = i_ir[31:26];
    assign w_funct = i_ir[5:0];

    always_comb begin
        o_aluop       = ALU_AND;
        o_alu_src_imm = 1'b0;
        o_wr_en       = 1'b0;
        o_legal       = 1'b0;
        if (i_ir == 32'h0000_0000) begin
            // All-zero word is the canonical nop: legal but writes nothing,
            // even though it shares the R-type opcode.
            o_legal = 1'b1;
        end else if (w_op == OP_RTYPE) begin
            o_legal = 1'b1;
            o_wr_en = 1'b1;
            case (w_funct)
                FN_ADD:  o_aluop = ALU_ADD;
                FN_SUB:  o_aluop = ALU_SUB;
                FN_AND:  o_aluop = ALU_AND;
                FN_OR:   o_aluop = ALU_OR;
                FN_SLT:  o_aluop = ALU_SLT;
                default: begin
                    o_legal = 1'b0;
                    o_wr_en = 1'b0;
                end
            endcase
        end else if (w_op == OP_ADDI) begin
            o_legal       = 1'b1;
            o_wr_en       = 1'b1;
            o_aluop       = ALU_ADD;
            o_alu_src_imm = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mc_sequencer
//  Purpose  : Multi-cycle control sequencer for the single-issue MIPS
//             datapath. Fetches over a req/ack handshake, latches the
//             instruction and steps it through DECODE, EXEC and WB with
//             one-cycle datapath strobes. Provides halt, illegal-instruction
//             trap, fetch watchdog and a retired-instruction counter.
//  Ports    : clk, rst (async, active-high)
//             instr, imem_ack      - instruction memory return
//             halt                 - level stop request
//             imem_req, ir_load    - fetch handshake / IR capture pulse
//             alu_en, aluop, alu_src_imm, regwrite, pc_en - datapath control
//             state                - current FSM state
//             illegal, timeout     - sticky trap causes
//             retired              - completed instruction count (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int RETIRE_W      = 32,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                imem_ack,
    input  logic                halt,
    output logic                imem_req,
    output logic                ir_load,
    output logic                alu_en,
    output logic [2:0]          aluop,
    output logic                alu_src_imm,
    output logic                regwrite,
    output logic                pc_en,
    output logic [2:0]          state,
    output logic                illegal,
    output logic                timeout,
    output logic [RETIRE_W-1:0] retired
);

    // Watchdog counts ack-less FETCH cycles already spent; it must hold
    // values up to FETCH_TIMEOUT-1.
    localparam int c_WD_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(FETCH_TIMEOUT - 1);

    state_t              r_state;
    logic [31:0]         r_ir;
    logic [c_WD_W-1:0]   r_wdog;
    logic [RETIRE_W-1:0] r_retired;
    logic                r_illegal;
    logic                r_timeout;

    logic [2:0]          w_aluop;
    logic                w_alu_src_imm;
    logic                w_wr_en;
    logic                w_legal;

    mc_decode u_decode (
        .i_ir          (r_ir),
        .o_aluop       (w_aluop),
        .o_alu_src_imm (w_alu_src_imm),
        .o_wr_en       (w_wr_en),
        .o_legal       (w_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RESET;
            r_ir      <= '0;
            r_wdog    <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state <= ST_FETCH;
                    r_wdog  <= '0;
                end
                ST_FETCH: begin
                    // Ack is checked first: it beats halt, and an ack on the
                    // final watchdog cycle is still accepted.
                    if (imem_ack) begin
                        r_ir    <= instr;
                        r_state <= ST_DECODE;
                    end else if (halt) begin
                        r_state <= ST_HALTED;
                    end else if (r_wdog == c_WD_LAST) begin
                        r_state   <= ST_TRAP;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + c_WD_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (w_legal) begin
                        r_state <= ST_EXEC;
                    end else begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    r_retired <= r_retired + RETIRE_W'(1);
                    r_state   <= ST_FETCH;
                    r_wdog    <= '0;
                end
                ST_HALTED: begin
                    if (!halt) begin
                        r_state <= ST_FETCH;
                        r_wdog  <= '0;
                    end
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

    // Moore outputs decoded from registered state and IR only, so an
    // asynchronous reset forces every strobe low in the same cycle.
    always_comb begin
        imem_req    = 1'b0;
        alu_en      = 1'b0;
        aluop       = 3'b000;
        alu_src_imm = 1'b0;
        regwrite    = 1'b0;
        pc_en       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
            end
            ST_EXEC: begin
                alu_en      = 1'b1;
                aluop       = w_aluop;
                alu_src_imm = w_alu_src_imm;
            end
            ST_WB: begin
                aluop       = w_aluop;
                alu_src_imm = w_alu_src_imm;
                regwrite    = w_wr_en;
                pc_en       = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign ir_load = (r_state == ST_FETCH) && imem_ack;
    assign state   = r_state;
    assign illegal = r_illegal;
    assign timeout = r_timeout;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the single-issue MIPS datapath.
- Replaces purely combinational decode with an FSM that fetches over a req/ack handshake and latches the instruction internally.
- Steps each instruction through DECODE, EXEC and WB, emitting one-cycle strobes for the datapath: pc_en, alu_en, regwrite.
- Also provides halt, illegal-instruction trap, fetch watchdog and a retired-instruction counter.

Parameters:
RETIRE_W, 32, width of retired-instruction counter
FETCH_TIMEOUT, 16, max FETCH cycles without imem_ack before trap (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
instr  in  32  instruction word from instruction memory, valid when imem_ack=1
imem_ack  in  1  fetch acknowledge, single-cycle
halt  in  1  stop request, level
imem_req  out  1  fetch request, high throughout FETCH
ir_load  out  1  pulse: instr captured this cycle
alu_en  out  1  pulse in EXEC: datapath registers ALU result
aluop  out  3  ALU operation, valid in EXEC and WB, else 000
alu_src_imm  out  1  select sign-extended imm16 as ALU B, valid in EXEC/WB
regwrite  out  1  pulse in WB for writing instructions
pc_en  out  1  pulse in WB: PC <= PC+4
state  out  3  current FSM state encoding
illegal  out  1  sticky: trapped on undecodable instruction
timeout  out  1  sticky: trapped on fetch watchdog
retired  out  RETIRE_W  count of completed instructions, wraps

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- State encoding: RESET=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALTED=5, TRAP=6.
- Reset value: state=RESET. Internal IR=0, watchdog=0, retired=0, illegal=0, timeout=0.
- Outputs during RESET: all outputs 0 (state=0).
- RESET -> FETCH unconditionally on the first clock after rst deasserts.
- All outputs are Moore, decoded from state plus registered IR, except ir_load.
- ir_load = (state==FETCH) & imem_ack.
- FETCH:
  - imem_req=1.
  - On imem_ack: latch instr into IR, go to DECODE.
  - Else if halt: go to HALTED.
  - Else increment watchdog.
  - If FETCH_TIMEOUT cycles elapse without ack: go to TRAP, set timeout. An ack arriving on the FETCH_TIMEOUT-th cycle is accepted.
- Watchdog clears on every entry to FETCH.
- ack and halt in the same cycle: ack wins, and the instruction completes.
- DECODE: one cycle.
  - Legal IR -> EXEC.
  - Illegal IR -> TRAP, set illegal.
- EXEC: one cycle, alu_en=1. aluop and alu_src_imm driven.
- WB: one cycle, pc_en=1, retired+=1 (modulo 2^RETIRE_W), regwrite=1 if writing instruction. Then -> FETCH.
- HALTED: imem_req=0. halt=0 returns to FETCH on the next cycle.
- TRAP: absorbing; only rst exits. No strobes. illegal/timeout held.
- Minimum latency: 4 cycles per instruction (ack in first FETCH cycle). Throughput 1 instruction per 4+k cycles, where k = ack wait cycles.
- Decode, using IR[31:26]=op and IR[5:0]=funct:
  - IR==0 (nop): legal, aluop=000, regwrite=0.
  - op=0x00, funct 0x20 add -> 010; 0x22 sub -> 110; 0x24 and -> 000; 0x25 or -> 001; 0x2A slt -> 111. All regwrite=1, alu_src_imm=0.
  - op=0x08 addi -> aluop 010, alu_src_imm=1, regwrite=1.
  - Anything else is illegal.
- imem_ack outside FETCH: ignored; IR unchanged.
- Reset mid-instruction: immediate abort. No partial regwrite or pc_en may appear after rst rises.

Decomposition:
- Package mc_pkg:
  - state_t enum with the encodings above.
  - OP_RTYPE, OP_ADDI constants.
  - FN_ADD/SUB/AND/OR/SLT constants.
  - ALU_AND/OR/ADD/SUB/SLT constants.
- Sub-module mc_decode: combinational, IR in -> aluop, alu_src_imm, wr_en, legal out. Shared by the sequencer and the bench reference model.
- mc_sequencer holds the FSM, IR, watchdog and counters.

Test Plan:
- Reset then ack every FETCH with add (0x012A4020) -> strobe sequence ir_load, alu_en(aluop=010), regwrite+pc_en, repeated every 4 cycles; retired=3 after 12 cycles post-RESET.
- addi 0x2128FFFF with ack delayed 5 cycles -> imem_req high 6 cycles, alu_src_imm=1 in EXEC/WB, regwrite pulse once, retired+1.
- nop 0x00000000 -> pc_en pulses, regwrite stays 0, retired increments.
- Illegal 0xFC000000 -> DECODE then state=6, illegal=1, no pc_en, retired unchanged, imem_req 0 thereafter until rst.
- No ack with FETCH_TIMEOUT=16 -> after 16 FETCH cycles, state=6, timeout=1; separately, ack on cycle 16 -> normal DECODE, timeout=0.
- halt=1 with ack in same FETCH cycle -> instruction retires, next FETCH without ack enters HALTED (5). halt=0 -> FETCH next cycle. rst asserted during EXEC -> all outputs 0 same cycle, retired=0.
